// File: rtl/decode_pkg.sv
// Shared decode definitions for decode_stage_q: opcode groups, control encodings
// and the pure opcode -> control decode function.
package decode_pkg;

  localparam logic [1:0] OPG_BR  = 2'b00;
  localparam logic [1:0] OPG_ALU = 2'b01;
  localparam logic [1:0] OPG_LD  = 2'b10;
  localparam logic [1:0] OPG_ST  = 2'b11;

  localparam logic [1:0] W_SRC_ALU = 2'd0;
  localparam logic [1:0] W_SRC_MEM = 2'd1;
  localparam logic [1:0] W_SRC_PC  = 2'd2;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;
  } e_ctrl_t;

  typedef struct packed {
    e_ctrl_t    e;
    logic       mem;
    logic [1:0] w;
  } dec_t;

  // op is the 4-bit opcode, imm_bit is instr[5] (register/immediate select).
  function automatic dec_t decode_op(input logic [3:0] op, input logic imm_bit);
    dec_t d;
    d = '0;
    case (op[1:0])
      OPG_BR: begin
        case (op[3:2])
          2'b00: begin
            d.e.pcsel1 = 2'd1;
            d.e.pcsel2 = 1'b1;
          end
          2'b11: d.e.pcsel1 = 2'd3;
          default: ;
        endcase
      end
      OPG_ALU: begin
        d.e.op2sel = ~imm_bit;
        d.e.alu    = (op[3:2] == 2'b11) ? 2'd0 : op[3:2];
      end
      default: begin
        if (op[3:2] == 2'b01) begin
          d.e.pcsel1 = 2'd2;
        end else begin
          d.e.pcsel1 = 2'd1;
          d.e.pcsel2 = 1'b1;
        end
        d.mem = (op[3:2] == 2'b10);
        if (op[1:0] == OPG_LD)
          d.w = (op[3:2] == 2'b11) ? W_SRC_PC : W_SRC_MEM;
        else
          d.w = W_SRC_ALU;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Circular buffer of DEPTH entries (power of two) with occupancy count and flush.
module decode_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/decode_stage_q.sv
// Queued LC-3 decode stage: instruction FIFO feeding a registered decode slot.
// Optional macro DECODE_BYPASS_EN decodes straight into the slot when the queue is empty.
module decode_stage_q
  import decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_npc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] IR,
  output logic [PC_W-1:0]    npc_out,
  output logic [5:0]         E_Control,
  output logic               Mem_Control,
  output logic [1:0]         W_Control,
  output logic [CNT_W-1:0]   occupancy
);

  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_npc;
  logic               w_accept;
  logic               w_slot_free;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic [INSTR_W-1:0] w_src_instr;
  logic [PC_W-1:0]    w_src_npc;
  dec_t               w_dec;

  logic               r_vld_p1;
  logic [INSTR_W-1:0] r_ir_p1;
  logic [PC_W-1:0]    r_npc_p1;
  e_ctrl_t            r_e_p1;
  logic               r_mem_p1;
  logic [1:0]         r_w_p1;

  // A full queue refuses input even if the head pops this cycle.
  assign in_ready    = !w_full && !reset;
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_slot_free = !r_vld_p1 || out_ready;

`ifdef DECODE_BYPASS_EN
  assign w_bypass = w_accept && w_empty && w_slot_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  assign w_pop  = w_slot_free && !w_empty && !flush;
  assign w_load = w_pop || w_bypass;

  assign w_src_instr = w_bypass ? in_instr : w_head_instr;
  assign w_src_npc   = w_bypass ? in_npc   : w_head_npc;
  assign w_dec       = decode_op(w_src_instr[INSTR_W-1 -: 4], w_src_instr[5]);

  decode_fifo #(
    .DATA_W (INSTR_W + PC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .flush (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({in_instr, in_npc}),
    .dout  ({w_head_instr, w_head_npc}),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // ---- stage p1: registered decode slot ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_ir_p1  <= '0;
      r_npc_p1 <= '0;
      r_e_p1   <= '0;
      r_mem_p1 <= 1'b0;
      r_w_p1   <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_load) begin
      r_vld_p1 <= 1'b1;
      r_ir_p1  <= w_src_instr;
      r_npc_p1 <= w_src_npc;
      r_e_p1   <= w_dec.e;
      r_mem_p1 <= w_dec.mem;
      r_w_p1   <= w_dec.w;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = r_vld_p1;
  assign IR          = r_ir_p1;
  assign npc_out     = r_npc_p1;
  assign E_Control   = r_e_p1;
  assign Mem_Control = r_mem_p1;
  assign W_Control   = r_w_p1;
  assign occupancy   = w_count;

endmodule

// File: tb/tb_decode_stage_q.sv
// Self-checking bench for decode_stage_q: vector table through a scoreboard plus
// hand-written backpressure, flush and reset sequences.
module tb_decode_stage_q;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    logic [5:0]  e;
    logic        mem;
    logic [1:0]  w;
  } vec_t;

`ifdef DECODE_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_npc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic        Mem_Control;
  logic [1:0]  W_Control;
  logic [2:0]  occupancy;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t vecs[14];
  vec_t mon_exp;
  int   lat;

  decode_stage_q dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_npc      (in_npc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .IR          (IR),
    .npc_out     (npc_out),
    .E_Control   (E_Control),
    .Mem_Control (Mem_Control),
    .W_Control   (W_Control),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input vec_t v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_npc   = v.npc;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(v);
        break;
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout instr=%h", v.instr);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (10) @(negedge clock);
    chk("sb_empty_after_drain", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output IR=%h required=none", IR);
      end else begin
        mon_exp = sb.pop_front();
        chk("IR", IR, mon_exp.instr);
        chk("npc_out", npc_out, mon_exp.npc);
        chk("E_Control", E_Control, mon_exp.e);
        chk("Mem_Control", Mem_Control, mon_exp.mem);
        chk("W_Control", W_Control, mon_exp.w);
      end
    end
  end

  initial begin
    vecs[0]  = '{16'h1042, 16'h3001, 6'b000001, 1'b0, 2'd0};
    vecs[1]  = '{16'h5020, 16'h3002, 6'b010000, 1'b0, 2'd0};
    vecs[2]  = '{16'h903F, 16'h3003, 6'b100000, 1'b0, 2'd0};
    vecs[3]  = '{16'hC000, 16'h3004, 6'b001100, 1'b0, 2'd0};
    vecs[4]  = '{16'h0000, 16'h3005, 6'b000110, 1'b0, 2'd0};
    vecs[5]  = '{16'hE005, 16'h3006, 6'b000110, 1'b0, 2'd2};
    vecs[6]  = '{16'hA010, 16'h3007, 6'b000110, 1'b1, 2'd1};
    vecs[7]  = '{16'h6040, 16'h3008, 6'b001000, 1'b0, 2'd1};
    vecs[8]  = '{16'hB000, 16'h3009, 6'b000110, 1'b1, 2'd0};
    vecs[9]  = '{16'h1060, 16'h300A, 6'b000000, 1'b0, 2'd0};
    vecs[10] = '{16'h7000, 16'h300B, 6'b001000, 1'b0, 2'd0};
    vecs[11] = '{16'h9000, 16'h300C, 6'b100001, 1'b0, 2'd0};
    vecs[12] = '{16'h2000, 16'h300D, 6'b000110, 1'b0, 2'd1};
    vecs[13] = '{16'hD020, 16'h300E, 6'b000000, 1'b0, 2'd0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_npc    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_IR", IR, 0);
    chk("rst_E", E_Control, 0);
    chk("rst_W", W_Control, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1);

    // First-instruction latency
    @(posedge clock);
    #1;
    push(vecs[0]);
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, EXP_LAT);

    // Table stream back-to-back, then with random backpressure
    @(posedge clock);
    #1;
    for (int i = 1; i < 14; i++) push(vecs[i]);
    drain();
    for (int i = 0; i < 14; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      push(vecs[i]);
    end
    drain();

    // Backpressure: fill slot + DEPTH queue entries
    out_ready = 1'b0;
    for (int i = 5; i < 10; i++) push(vecs[i]);
    @(negedge clock);
    chk("full_occupancy", occupancy, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_slot_IR", IR, vecs[5].instr);
    in_valid = 1'b1;
    in_instr = vecs[10].instr;
    in_npc   = vecs[10].npc;
    repeat (3) begin
      @(negedge clock);
      chk("held_in_ready", in_ready, 0);
      chk("held_occupancy", occupancy, 4);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    push(vecs[10]);
    drain();

    // Flush with 3 queued and a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[i]);
    @(negedge clock);
    chk("pre_flush_occupancy", occupancy, 3);
    @(posedge clock);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h5020;
    in_npc   = 16'h4000;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_IR_hold", IR, vecs[0].instr);
    chk("flush_E_hold", E_Control, vecs[0].e);
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("flush_dropped", out_valid, 0);
    @(posedge clock);
    #1;

    // Reset mid-stream
    out_ready = 1'b0;
    push(vecs[1]);
    push(vecs[2]);
    @(negedge clock);
    chk("mid_out_valid", out_valid, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_hi_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    sb.delete();
    @(negedge clock);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_IR", IR, 0);
    chk("mid_rst_npc", npc_out, 0);
    chk("mid_rst_E", E_Control, 0);
    chk("mid_rst_Mem", Mem_Control, 0);
    chk("mid_rst_W", W_Control, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("rel_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    push(vecs[7]);
    push(vecs[8]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
